// File: rtl/ucode_pkg.sv
// ucode_pkg: shared constants, instruction field layout and loader state encoding.
// Contents: WORD_W/ADDR_W/HDR, op codes, field LSB positions, state enum, pack_word helper.
package ucode_pkg;
   localparam int         WORD_W    = 26;
   localparam int         ADDR_W    = 9;
   localparam logic [7:0] HDR       = 8'hA5;
   localparam int         DEST_LSB  = 20;
   localparam int         SRC1_LSB  = 14;
   localparam int         OP_LSB    = 12;
   localparam int         TIMES_LSB = 6;
   localparam int         SRC2_LSB  = 0;
   typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, CUBIC = 2'd2, MULT = 2'd3} op_e;
   typedef enum logic [2:0] {IDLE, COUNT, B0, B1, B2, B3, CSUM, START} state_e;
   function automatic logic [WORD_W-1:0] pack_word(input logic [5:0] dest, input logic [5:0] src1,
                                                  input op_e op, input logic [5:0] times,
                                                  input logic [5:0] src2);
      return {dest, src1, op, times, src2};
   endfunction
endpackage

// File: rtl/microcode_loader.sv
// microcode_loader: unpacks a framed host byte stream into program RAM writes and starts the FSM.
// Ports: clk/reset_n (async active-low); in_data/in_valid/in_ready byte handshake;
//        prog_addr/prog_data/prog_w RAM write port; fsm_reset start pulse; load_done/err frame status.
module microcode_loader
   import ucode_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [WORD_W-1:0] prog_data,
   output logic              prog_w,
   output logic              fsm_reset,
   output logic              load_done,
   output logic              err
);
   state_e            r_state;
   logic              r_ready;
   logic              r_prog_w;
   logic              r_fsm_reset;
   logic              r_load_done;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_data;
   logic [17:0]       r_sh;
   logic [7:0]        r_csum;
   logic [7:0]        r_n;
   logic [7:0]        r_idx;
   logic              w_hs;
   logic [7:0]        w_csum_nxt;
   assign w_hs       = in_valid && r_ready;
   assign w_csum_nxt = r_csum ^ in_data;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_ready     <= 1'b0;
         r_prog_w    <= 1'b0;
         r_fsm_reset <= 1'b0;
         r_load_done <= 1'b0;
         r_err       <= 1'b0;
         r_addr      <= '0;
         r_data      <= '0;
         r_sh        <= '0;
         r_csum      <= '0;
         r_n         <= '0;
         r_idx       <= '0;
      end else begin
         r_prog_w    <= 1'b0;
         r_fsm_reset <= 1'b0;
         r_ready     <= 1'b1;
         case (r_state)
            IDLE: if (w_hs && in_data == HDR) begin
               r_state     <= COUNT;
               r_load_done <= 1'b0;
               r_err       <= 1'b0;
               r_idx       <= '0;
               r_csum      <= '0;
            end
            COUNT: if (w_hs) begin
               r_state <= (in_data == 8'd0) ? IDLE : B0;
               r_err   <= (in_data == 8'd0);
               r_n     <= in_data;
            end
            // Only two payload bits exist in byte 0; anything above them aborts the frame.
            B0: if (w_hs) begin
               r_state       <= (in_data[7:2] != 6'd0) ? IDLE : B1;
               r_err         <= (in_data[7:2] != 6'd0);
               r_sh[17:16]   <= in_data[1:0];
               r_csum        <= w_csum_nxt;
            end
            B1: if (w_hs) begin
               r_state     <= B2;
               r_sh[15:8]  <= in_data;
               r_csum      <= w_csum_nxt;
            end
            B2: if (w_hs) begin
               r_state    <= B3;
               r_sh[7:0]  <= in_data;
               r_csum     <= w_csum_nxt;
            end
            B3: if (w_hs) begin
               r_state  <= (r_idx + 8'd1 == r_n) ? CSUM : B0;
               r_data   <= {r_sh, in_data};
               r_addr   <= ADDR_W'(r_idx);
               r_prog_w <= 1'b1;
               r_idx    <= r_idx + 8'd1;
               r_csum   <= w_csum_nxt;
            end
            // A match drops in_ready for the one-cycle START bubble that carries the pulse.
            CSUM: if (w_hs) begin
               r_state     <= (in_data == r_csum) ? START : IDLE;
               r_err       <= (in_data != r_csum);
               r_fsm_reset <= (in_data == r_csum);
               r_load_done <= (in_data == r_csum);
               r_ready     <= (in_data != r_csum);
            end
            START: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign in_ready  = r_ready;
   assign prog_addr = r_addr;
   assign prog_data = r_data;
   assign prog_w    = r_prog_w;
   assign fsm_reset = r_fsm_reset;
   assign load_done = r_load_done;
   assign err       = r_err;
endmodule

// File: tb/tb_microcode_loader.sv
// tb_microcode_loader: randomized self-checking bench for microcode_loader against a frame-level model.
module tb_microcode_loader;
   import ucode_pkg::*;
   typedef struct {logic [ADDR_W-1:0] a; logic [WORD_W-1:0] d;} wr_t;
   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] prog_addr;
   logic [WORD_W-1:0] prog_data;
   logic              prog_w;
   logic              fsm_reset;
   logic              load_done;
   logic              err;
   int                n_chk = 0;
   int                n_fail = 0;
   logic [7:0]        stim[$];
   logic [WORD_W-1:0] wq[$];
   wr_t               got_q[$];
   wr_t               exp_q[$];
   int                got_pulses = 0;
   int                exp_pulses = 0;
   logic              m_ld = 1'b0;
   logic              m_err = 1'b0;
   logic [WORD_W-1:0] ram [0:255];
   bit                gaps = 1'b0;
   logic              prev_pw = 1'b0;
   logic              prev_fr = 1'b0;

   microcode_loader dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_w(prog_w), .fsm_reset(fsm_reset),
      .load_done(load_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (prog_w) begin
            check("prog_w_one_cycle", 32'(prev_pw), 32'd0);
            got_q.push_back('{prog_addr, prog_data});
            ram[prog_addr[7:0]] = prog_data;
         end
         if (fsm_reset) begin
            got_pulses++;
            check("fsm_reset_one_cycle", 32'(prev_fr), 32'd0);
            check("start_bubble_ready", 32'(in_ready), 32'd0);
            check("done_with_pulse", 32'(load_done), 32'd1);
         end
      end
      prev_pw = prog_w;
      prev_fr = fsm_reset;
   end

   task automatic send_byte(input logic [7:0] b);
      int gap = (gaps && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      bit done = 1'b0;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) check("handshake_timeout", 32'd0, 32'd1);
   endtask

   task automatic add_frame(input int kind);
      logic [7:0] cs = 8'h00;
      logic [7:0] b[4];
      int bad = $urandom_range(0, wq.size() - 1);
      stim.push_back(HDR);
      if (kind == 2) begin
         stim.push_back(8'h00);
         return;
      end
      stim.push_back(8'(wq.size()));
      foreach (wq[i]) begin
         if (kind == 3 && i == bad) begin
            stim.push_back({6'($urandom_range(1, 63)), 2'($urandom_range(0, 3))});
            return;
         end
         b[0] = {6'b0, wq[i][25:24]};
         b[1] = wq[i][23:16];
         b[2] = wq[i][15:8];
         b[3] = wq[i][7:0];
         for (int k = 0; k < 4; k++) begin
            stim.push_back(b[k]);
            cs ^= b[k];
         end
      end
      stim.push_back(kind == 1 ? cs ^ 8'(1 << $urandom_range(0, 7)) : cs);
   endtask

   task automatic run_model();
      int         i = 0;
      int         n;
      logic [7:0] b;
      logic [7:0] cs;
      bit         ok;
      while (i < stim.size()) begin
         b = stim[i];
         i++;
         if (b != HDR) continue;
         m_ld  = 1'b0;
         m_err = 1'b0;
         n = int'(stim[i]);
         i++;
         if (n == 0) begin
            m_err = 1'b1;
            continue;
         end
         cs = 8'h00;
         ok = 1'b1;
         for (int k = 0; k < n && ok; k++) begin
            b = stim[i];
            if (b[7:2] != 6'd0) begin
               m_err = 1'b1;
               ok = 1'b0;
               i++;
            end else begin
               exp_q.push_back('{ADDR_W'(k), {b[1:0], stim[i+1], stim[i+2], stim[i+3]}});
               cs ^= b ^ stim[i+1] ^ stim[i+2] ^ stim[i+3];
               i += 4;
            end
         end
         if (!ok) continue;
         b = stim[i];
         i++;
         if (b == cs) begin
            m_ld = 1'b1;
            exp_pulses++;
         end else m_err = 1'b1;
      end
   endtask

   task automatic run_scenario(input string tag);
      run_model();
      foreach (stim[i]) send_byte(stim[i]);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_nwr"}, got_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < got_q.size()) begin
            check({tag, "_addr"}, 32'(got_q[i].a), 32'(exp_q[i].a));
            check({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
         end
      end
      check({tag, "_pulses"}, got_pulses, exp_pulses);
      check({tag, "_load_done"}, 32'(load_done), 32'(m_ld));
      check({tag, "_err"}, 32'(err), 32'(m_err));
      stim.delete();
      wq.delete();
      got_q.delete();
      exp_q.delete();
      got_pulses = 0;
      exp_pulses = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_addr"}, 32'(prog_addr), 32'd0);
      check({tag, "_data"}, 32'(prog_data), 32'd0);
      check({tag, "_pw"}, 32'(prog_w), 32'd0);
      check({tag, "_fsm_reset"}, 32'(fsm_reset), 32'd0);
      check({tag, "_load_done"}, 32'(load_done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #12;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_edge", 32'(in_ready), 32'd1);

      wq.push_back(26'h0A8104C);
      add_frame(0);
      run_model();
      for (int i = 0; i < 6; i++) send_byte(stim[i]);
      check("add_pw_timing", 32'(prog_w), 32'd1);
      check("add_addr", 32'(prog_addr), 32'd0);
      check("add_data", 32'(prog_data), 32'h0A8104C);
      send_byte(stim[6]);
      in_valid = 1'b0;
      check("add_fsm_reset", 32'(fsm_reset), 32'd1);
      check("add_load_done", 32'(load_done), 32'd1);
      check("add_start_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("add_fsm_reset_drop", 32'(fsm_reset), 32'd0);
      check("add_load_sticky", 32'(load_done), 32'd1);
      check("add_pulses", got_pulses, exp_pulses);
      stim.delete();
      wq.delete();
      got_q.delete();
      exp_q.delete();
      got_pulses = 0;
      exp_pulses = 0;

      gaps = 1'b1;
      wq.push_back(pack_word(6'd10, 6'd11, ADD, 6'd1, 6'd12));
      wq.push_back(pack_word(6'd13, 6'd10, SUB, 6'd2, 6'd11));
      wq.push_back(pack_word(6'd14, 6'd13, CUBIC, 6'd3, 6'd0));
      wq.push_back(pack_word(6'd15, 6'd14, MULT, 6'd5, 6'd13));
      begin
         logic [WORD_W-1:0] prog[4];
         foreach (prog[i]) prog[i] = wq[i];
         add_frame(0);
         run_scenario("prog4");
         foreach (prog[i]) check("prog4_ram", 32'(ram[i]), 32'(prog[i]));
      end

      wq.push_back(26'h0A8104C);
      add_frame(0);
      stim[stim.size()-1] = 8'h00;
      run_scenario("bad_csum");
      wq.push_back(26'h3FFFFFF);
      wq.push_back(26'h0000001);
      add_frame(0);
      run_scenario("good_after_bad");

      add_frame(2);
      run_scenario("n_zero");
      stim = '{8'hA5, 8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
      run_scenario("bad_b0");

      stim = '{8'h00, 8'hFF, 8'h37};
      wq.push_back(26'h1A5A5A5);
      add_frame(0);
      run_scenario("noise_hdr_data");

      gaps = 1'b0;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'hA8);
      in_valid = 1'b0;
      reset_n = 1'b0;
      #2;
      check_all_zero("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_no_write", got_q.size(), 0);
      check("midrst_no_pulse", got_pulses, 0);
      m_ld = 1'b0;
      m_err = 1'b0;
      wq.push_back(26'h2345678);
      add_frame(0);
      run_scenario("after_rst");

      for (int r = 0; r < 25; r++) begin
         int nw = $urandom_range(1, 6);
         gaps = ($urandom_range(0, 1) == 1);
         repeat ($urandom_range(0, 2)) stim.push_back(8'($urandom_range(0, 164)));
         for (int k = 0; k < nw; k++) wq.push_back(WORD_W'($urandom()));
         add_frame($urandom_range(0, 3));
         run_scenario("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
